// File: rtl/my_retime_pkg.sv
// Shared definitions for the programmable-latency retiming pipeline.
package my_retime_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Force a requested latency into the legal range 1..depth.
  function automatic int unsigned clamp_lat(input int unsigned req, input int unsigned depth);
    if (req == 0) return 1;
    if (req > depth) return depth;
    return req;
  endfunction

endpackage

// File: rtl/my_retime_stage.sv
// One pipeline slot: a valid bit plus its data word, loaded together.
module my_retime_stage
  import my_retime_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Capture the upstream slot whenever this slot is allowed to advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= src_valid;
      data  <= src_data;
    end
  end

endmodule

// File: rtl/my_retime_pipe.sv
// Elastic valid/ready register pipeline with programmable latency 1..DEPTH.
// Words enter at stage DEPTH-L and always leave from stage DEPTH-1, so the
// number of register hops equals the latency in force.
module my_retime_pipe
  import my_retime_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LW    = $clog2(DEPTH + 1),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LW-1:0]    cfg_lat,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy,
  output logic [LW-1:0]    lat_active
);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [LW-1:0]    entry;
  logic [LW-1:0]    lat_clamped;
  logic             accept;
  logic             emit;

  assign entry       = LW'(DEPTH) - lat_active;
  assign lat_clamped = LW'(clamp_lat(32'(cfg_lat), DEPTH));
  assign out_valid   = v_q[DEPTH-1];
  assign out_data    = d_q[DEPTH-1];
  assign accept      = in_valid & in_ready;
  assign emit        = out_valid & out_ready;

  // Ready ripples back from the output; an empty slot anywhere ahead lets everything behind it move.
  always_comb begin
    rdy[DEPTH-1] = !v_q[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = !v_q[i] | rdy[i+1];
    end
  end

  // Select each slot's source (input at the entry slot, predecessor elsewhere) and gate loads to used slots.
  always_comb begin
    in_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      src_v[i] = in_valid;
      src_d[i] = in_data;
      load[i]  = (LW'(i) >= entry) && rdy[i];
      if (entry == LW'(i)) in_ready = rdy[i];
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (entry != LW'(i)) begin
        src_v[i] = v_q[i-1];
        src_d[i] = d_q[i-1];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    my_retime_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .src_valid (src_v[g]),
      .src_data  (src_d[g]),
      .valid     (v_q[g]),
      .data      (d_q[g])
    );
  end

  // Occupancy tracks accepts minus emits; latency only switches over on an idle, empty pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy  <= '0;
      lat_active <= LW'(DEPTH);
    end else begin
      case ({accept, emit})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
      if (occupancy == '0 && !accept) lat_active <= lat_clamped;
    end
  end

endmodule

// File: tb/tb_my_retime_pipe.sv
// Directed bench for my_retime_pipe with a queue-based reference model.
module tb_my_retime_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic [LW-1:0]    cfg_lat;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    occupancy;
  logic [LW-1:0]    lat_active;

  my_retime_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_lat    (cfg_lat),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .lat_active (lat_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words in flight with the earliest cycle each may be presented.
  typedef struct {
    int d;
    int avail;
  } ent_t;

  ent_t q[$];
  int   lat_m = DEPTH;
  int   cyc   = 0;

  // Observed traffic, used by the directed literal checks.
  int acc_d[$];
  int acc_c[$];
  int emit_d[$];
  int emit_c[$];

  function automatic int clamp_m(input int c);
    if (c == 0) return 1;
    if (c > DEPTH) return DEPTH;
    return c;
  endfunction

  always @(negedge clk) begin
    int   occ_before;
    logic ev;
    logic acc;
    if (!rst_n) begin
      q.delete();
      lat_m = DEPTH;
    end else begin
      occ_before = q.size();
      ev = (q.size() > 0) && (q[0].avail <= cyc);
      check("out_valid", int'(out_valid), int'(ev));
      if (ev) check("out_data", int'(out_data), q[0].d);
      check("in_ready", int'(in_ready), int'((q.size() < lat_m) || out_ready));
      check("occupancy", int'(occupancy), q.size());
      check("lat_active", int'(lat_active), lat_m);
      if (out_valid && out_ready) begin
        emit_d.push_back(int'(out_data));
        emit_c.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        acc_d.push_back(int'(in_data));
        acc_c.push_back(cyc);
      end
      acc = in_valid && ((q.size() < lat_m) || out_ready);
      if (ev && out_ready) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].avail < cyc + 1) q[0].avail = cyc + 1;
      end
      if (acc) q.push_back('{int'(in_data), cyc + lat_m});
      if (occ_before == 0 && !acc) lat_m = clamp_m(int'(cfg_lat));
    end
    cyc++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_d.delete();
    acc_c.delete();
    emit_d.delete();
    emit_c.delete();
  endtask

  task automatic push(input int d);
    in_valid = 1'b1;
    in_data  = WIDTH'(d);
    wait_cycles(1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_lat   = LW'(4);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset then idle
    wait_cycles(3);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_lat_active", int'(lat_active), 4);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    wait_cycles(2);

    // Streaming at latency 4
    clear_log();
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(k);
      wait_cycles(1);
      if (k == 8) check("stream_occupancy", int'(occupancy), 4);
    end
    in_valid = 1'b0;
    wait_cycles(6);
    check("stream_count", emit_d.size(), 16);
    for (int j = 0; j < emit_d.size() && j < acc_c.size(); j++) begin
      check("stream_data", emit_d[j], j + 1);
      check("stream_latency", emit_c[j] - acc_c[j], 4);
      if (j > 0) check("stream_gap", emit_c[j] - emit_c[j-1], 1);
    end

    // Back-pressure
    clear_log();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(8'hA0 + k);
    wait_cycles(5);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_occupancy", int'(occupancy), 4);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_out_data", int'(out_data), 8'hA0);
    out_ready = 1'b1;
    wait_cycles(6);
    check("bp_count", emit_d.size(), 4);
    for (int j = 0; j < emit_d.size(); j++) begin
      check("bp_data", emit_d[j], 8'hA0 + j);
      if (j > 0) check("bp_gap", emit_c[j] - emit_c[j-1], 1);
    end

    // Latency change while data is in flight
    clear_log();
    for (int k = 0; k < 3; k++) push(8'hB0 + k);
    cfg_lat = LW'(2);
    check("lc_occupancy", int'(occupancy), 3);
    check("lc_lat_hold0", int'(lat_active), 4);
    wait_cycles(3);
    check("lc_lat_hold1", int'(lat_active), 4);
    wait_cycles(2);
    check("lc_lat_new", int'(lat_active), 2);
    clear_log();
    push(8'hC5);
    wait_cycles(4);
    check("lc_count", emit_d.size(), 1);
    if (emit_d.size() > 0 && acc_c.size() > 0) begin
      check("lc_data", emit_d[0], 8'hC5);
      check("lc_latency", emit_c[0] - acc_c[0], 2);
    end

    // Accept in the same cycle as an empty-pipe cfg change keeps the old latency
    cfg_lat = LW'(4);
    push(8'hC6);
    check("same_cycle_lat", int'(lat_active), 2);
    wait_cycles(4);
    check("same_cycle_lat_later", int'(lat_active), 4);

    // Clamping
    cfg_lat = LW'(0);
    wait_cycles(2);
    check("clamp_low", int'(lat_active), 1);
    clear_log();
    push(8'hD1);
    wait_cycles(3);
    if (emit_d.size() > 0 && acc_c.size() > 0) begin
      check("l1_data", emit_d[0], 8'hD1);
      check("l1_latency", emit_c[0] - acc_c[0], 1);
    end else begin
      check("l1_count", emit_d.size(), 1);
    end
    cfg_lat = LW'(7);
    wait_cycles(3);
    check("clamp_high", int'(lat_active), 4);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(8'hE0 + k);
    wait_cycles(1);
    check("ar_pre_valid", int'(out_valid), 1);
    check("ar_pre_occupancy", int'(occupancy), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", int'(out_valid), 0);
    check("ar_occupancy", int'(occupancy), 0);
    check("ar_out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    out_ready = 1'b1;
    wait_cycles(8);
    check("ar_no_stale", emit_d.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
